// File: rtl/led_pattern_engine.sv
// LED pattern generator: rotates, bounces or holds a WIDTH-bit pattern on a
// prescaled step tick, with runtime speed select, enable and pattern load.
module led_pattern_engine #(
  parameter int unsigned       WIDTH        = 8,
  parameter int unsigned       CLK_FREQ     = 8,
  parameter logic [WIDTH-1:0]  INIT_PATTERN = WIDTH'(8'b00011111),
  parameter int unsigned       BASE_DIV     = CLK_FREQ / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] leds,
  output logic             step_pulse,
  output logic             dir
);

  localparam int unsigned CNT_W = $clog2(BASE_DIV * 8) + 1;

  typedef enum logic [1:0] {
    MODE_ROL    = 2'b00,
    MODE_ROR    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] period;
  logic             tick;
  logic [WIDTH-1:0] leds_rol;
  logic [WIDTH-1:0] leds_ror;
  mode_t            mode_e;

  assign mode_e   = mode_t'(mode);
  assign period   = CNT_W'(BASE_DIV) << speed;
  // ">=" lets a mid-count speed decrease tick on the very next enabled cycle
  assign tick     = en && (counter >= period - CNT_W'(1));
  assign leds_rol = {leds[WIDTH-2:0], leds[WIDTH-1]};
  assign leds_ror = {leds[0], leds[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      leds       <= INIT_PATTERN;
      counter    <= '0;
      dir        <= 1'b0;
      step_pulse <= 1'b0;
    end else if (load) begin
      leds       <= load_value;
      counter    <= '0;
      dir        <= (mode_e == MODE_ROR);
      step_pulse <= 1'b0;
    end else if (tick) begin
      counter    <= '0;
      step_pulse <= 1'b1;
      case (mode_e)
        MODE_ROL: begin
          leds <= leds_rol;
          dir  <= 1'b0;
        end
        MODE_ROR: begin
          leds <= leds_ror;
          dir  <= 1'b1;
        end
        MODE_BOUNCE: begin
          // Reverse only when the lit edge is the one we are heading toward
          if (!dir) begin
            if (leds[WIDTH-1] && !leds[0]) begin
              dir  <= 1'b1;
              leds <= leds_ror;
            end else begin
              leds <= leds_rol;
            end
          end else begin
            if (leds[0] && !leds[WIDTH-1]) begin
              dir  <= 1'b0;
              leds <= leds_rol;
            end else begin
              leds <= leds_ror;
            end
          end
        end
        default: begin
          leds <= leds;
          dir  <= dir;
        end
      endcase
    end else begin
      step_pulse <= 1'b0;
      if (en) begin
        counter <= counter + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine: directed plan plus random stimulus,
// checked against a cycle-level behavioural model of the pattern rules.
module tb_led_pattern_engine;

  localparam int W        = 8;
  localparam int CLK_FREQ = 8;
  localparam int BASE_DIV = CLK_FREQ / 4;
  localparam int MASK     = (1 << W) - 1;
  localparam int INIT     = 8'h1F;

  typedef struct {
    int leds;
    int dir;
    int sp;
    int cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [1:0]   mode;
  logic [1:0]   speed;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] leds;
  logic         step_pulse;
  logic         dir;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cycle = 0;

  int   m_leds = 0;
  int   m_cnt  = 0;
  int   m_dir  = 0;
  int   m_sp   = 0;

  led_pattern_engine #(
    .WIDTH        (W),
    .CLK_FREQ     (CLK_FREQ),
    .INIT_PATTERN (8'b00011111),
    .BASE_DIV     (BASE_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .speed      (speed),
    .load       (load),
    .load_value (load_value),
    .leds       (leds),
    .step_pulse (step_pulse),
    .dir        (dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d actual=%h expected=%h", name, cycle, actual, expected);
    end
  endtask

  function automatic int rol(input int x);
    return ((x << 1) | (x >> (W - 1))) & MASK;
  endfunction

  function automatic int ror(input int x);
    return ((x >> 1) | ((x & 1) << (W - 1))) & MASK;
  endfunction

  // Drive one cycle of inputs, advance the model and queue the expected outputs
  task automatic applyStimulus(input bit r, input bit e, input bit [1:0] m,
                               input bit [1:0] s, input bit l, input bit [7:0] lv,
                               input bit glitch);
    int   period;
    int   msb;
    int   lsb;
    exp_t x;
    rst_n      = r;
    en         = e;
    mode       = m;
    speed      = s;
    load       = l;
    load_value = lv;
    period = BASE_DIV * (2 ** s);
    if (!r) begin
      m_leds = INIT; m_cnt = 0; m_dir = 0; m_sp = 0;
    end else if (l) begin
      m_leds = lv; m_cnt = 0; m_dir = (m == 2'b01) ? 1 : 0; m_sp = 0;
    end else if (e && m_cnt >= period - 1) begin
      m_cnt = 0;
      m_sp  = 1;
      msb   = (m_leds >> (W - 1)) & 1;
      lsb   = m_leds & 1;
      if (m == 2'b00) begin
        m_leds = rol(m_leds); m_dir = 0;
      end else if (m == 2'b01) begin
        m_leds = ror(m_leds); m_dir = 1;
      end else if (m == 2'b10) begin
        if (m_dir == 0 && msb == 1 && lsb == 0) m_dir = 1;
        else if (m_dir == 1 && lsb == 1 && msb == 0) m_dir = 0;
        m_leds = (m_dir == 0) ? rol(m_leds) : ror(m_leds);
      end
    end else begin
      m_sp = 0;
      if (e) m_cnt++;
    end
    x.leds = m_leds; x.dir = m_dir; x.sp = m_sp; x.cyc = cycle;
    exp_q.push_back(x);
    if (glitch && r) begin
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit [1:0] m, input bit [1:0] s);
    for (int i = 0; i < n; i++) applyStimulus(1, 1, m, s, 0, 8'h00, 0);
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: every edge the DUT presents a new output word; compare it to the queue head
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checkOutput("leds", 32'(leds), 32'(x.leds));
        checkOutput("dir", 32'(dir), 32'(x.dir));
        checkOutput("step_pulse", 32'(step_pulse), 32'(x.sp));
      end
    end
  end

  initial begin
    int wait_cycles;
    rst_n = 1'b1; en = 1'b0; mode = 2'b00; speed = 2'b00; load = 1'b0; load_value = '0;
    @(negedge clk);

    applyStimulus(0, 0, 0, 0, 0, 8'h00, 0);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 0);
    checkOutput("reset_leds", 32'(leds), 32'h1F);
    checkOutput("reset_dir", 32'(dir), 32'h0);

    run(10, 2'b00, 2'b00);
    checkOutput("rol_seq", 32'(leds), 32'hE3);

    run(1, 2'b00, 2'b00);
    applyStimulus(1, 1, 2'b00, 2'b00, 1, 8'h81, 0);
    checkOutput("load_collide", 32'(leds), 32'h81);
    checkOutput("load_no_pulse", 32'(step_pulse), 32'h0);
    run(2, 2'b00, 2'b00);
    checkOutput("after_load_rol", 32'(leds), 32'h03);

    applyStimulus(1, 1, 2'b10, 2'b00, 1, 8'h1F, 0);
    run(12, 2'b10, 2'b00);
    checkOutput("bounce_back", 32'(leds), 32'h1F);
    checkOutput("bounce_dir1", 32'(dir), 32'h1);
    run(2, 2'b10, 2'b00);
    checkOutput("bounce_fwd", 32'(leds), 32'h3E);
    checkOutput("bounce_dir0", 32'(dir), 32'h0);

    applyStimulus(1, 1, 2'b01, 2'b10, 1, 8'h1F, 0);
    run(8, 2'b01, 2'b10);
    checkOutput("ror_slow1", 32'(leds), 32'h8F);
    run(8, 2'b01, 2'b10);
    checkOutput("ror_slow2", 32'(leds), 32'hC7);
    checkOutput("ror_dir", 32'(dir), 32'h1);
    run(3, 2'b01, 2'b10);
    run(1, 2'b01, 2'b00);
    checkOutput("speed_drop", 32'(leds), 32'hE3);

    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 2'b00, 2'b00, 0, 8'h00, 0);
    checkOutput("freeze", 32'(leds), 32'hE3);
    run(8, 2'b11, 2'b00);
    checkOutput("hold", 32'(leds), 32'hE3);

    applyStimulus(1, 1, 2'b00, 2'b00, 1, 8'h1F, 0);
    run(7, 2'b00, 2'b00);
    checkOutput("pre_reset", 32'(leds), 32'hF8);
    applyStimulus(0, 1, 2'b00, 2'b00, 0, 8'h00, 0);
    checkOutput("mid_reset", 32'(leds), 32'h1F);
    applyStimulus(1, 1, 2'b00, 2'b00, 0, 8'h00, 1);
    checkOutput("glitch_ignored", 32'(leds), 32'h1F);
    run(1, 2'b00, 2'b00);
    checkOutput("post_glitch_tick", 32'(leds), 32'h3E);

    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 80),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 99) < 5), 8'($urandom), 0);
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) checkOutput("drain_timeout", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
